hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/md_busy_counter.sv | 35 +++
 rtl/hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg -- shared definitions for the pipeline hazard controller.
//   state_t        : FSM encoding (RUN=0, LU_STALL=1, MD_WAIT=2), also seen on the debug port
//   NOP            : instruction word loaded into IF/ID on a flush
//   MD_LATENCY_DEF : default number of cycles a multiply/divide occupies EX
//   MD_CNT_W       : width of the multiply/divide busy counter (covers latencies up to 15)
//   sat_inc        : saturating 32-bit increment for the optional performance counters
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MD_WAIT  = 2'd2
    } state_t;

    localparam logic [31:0] NOP            = 32'h0000_0000;
    localparam int          MD_LATENCY_DEF = 4;
    localparam int          MD_CNT_W       = 4;
    localparam logic [31:0] PERF_MAX       = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == PERF_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter -- down-counter tracking how long a multiply/divide still holds EX.
// Ports:
//   CLK, RST    : clock, asynchronous active-high reset (clears the count)
//   i_load      : load i_load_val (takes precedence over i_dec)
//   i_load_val  : value to load
//   i_dec       : decrement by one; holds at zero
//   o_zero      : count is zero
module md_busy_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller (load-use stall, multi-cycle EX wait,
// branch flush, instruction-fetch wait).
// Parameters:
//   MD_LATENCY : cycles a multiply/divide occupies EX (2..15)
//   REG_W      : register index width
// Ports:
//   CLK, RST                 : clock, asynchronous active-high reset
//   id_rs, id_rt             : source registers of the instruction in ID
//   ex_mem_read, ex_rt       : load in EX and its destination register
//   branch_taken             : branch/jump resolved taken in EX this cycle
//   md_start                 : multiply/divide enters EX this cycle
//   imem_ready               : fetch data presented to IF/ID is valid
//   pc_write, if_id_write    : PC / IF/ID update enables
//   if_id_flush              : load NOP into IF/ID
//   id_ex_bubble             : zero the ID/EX control fields
//   state                    : current FSM state (debug)
// Build option HAZARD_PERF_EN adds saturating 32-bit counters stall_cycles
// (cycles with pc_write=0) and flush_cycles (cycles with if_id_flush=1).
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int REG_W      = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             branch_taken,
    input  logic             md_start,
    input  logic             imem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [1:0]       state
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_cycles
`endif
);

    // Counter starts at MD_LATENCY-1 so MD_WAIT lasts MD_LATENCY cycles (N-1 .. 0).
    localparam logic [MD_CNT_W-1:0] LP_MD_LOAD = MD_CNT_W'(MD_LATENCY - 1);

    state_t r_state;
    state_t w_next;
    logic   w_load_use;
    logic   w_md_load;
    logic   w_md_dec;
    logic   w_md_zero;

    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    assign w_load_use = ex_mem_read && (ex_rt != '0) &&
                        ((ex_rt == id_rs) || (ex_rt == id_rt));

    md_busy_counter #(.CNT_W(MD_CNT_W)) u_md_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .i_load     (w_md_load),
        .i_load_val (LP_MD_LOAD),
        .i_dec      (w_md_dec),
        .o_zero     (w_md_zero)
    );

    always_comb begin
        w_next       = r_state;
        w_md_load    = 1'b0;
        w_md_dec     = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;

        case (r_state)
            RUN: begin
                // A taken branch kills the ID instruction, so nothing else in RUN matters.
                if (!branch_taken) begin
                    if (md_start) begin
                        w_md_load = 1'b1;
                        w_next    = MD_WAIT;
                    end else if (w_load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        w_next       = LU_STALL;
                    end else if (!imem_ready) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        if_id_flush = 1'b1;
                    end
                end
            end
            LU_STALL: begin
                w_next = RUN;
                if (!imem_ready) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    if_id_flush = 1'b1;
                end
            end
            MD_WAIT: begin
                // md_start is ignored here; branches only override outputs, so the
                // countdown keeps its original schedule.
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                if (w_md_zero) begin
                    w_next = RUN;
                end else begin
                    w_md_dec = 1'b1;
                end
            end
            default: w_next = RUN;
        endcase

        if (branch_taken) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end

        // Reset presents a clean NOP/bubble pipeline while PC loads its reset vector.
        if (RST) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    assign state = r_state;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_cycles;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cycles <= '0;
            r_flush_cycles <= '0;
        end else begin
            if (!pc_write)  r_stall_cycles <= sat_inc(r_stall_cycles);
            if (if_id_flush) r_flush_cycles <= sat_inc(r_flush_cycles);
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_cycles = r_flush_cycles;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- scoreboard bench for hazard_ctrl (MD_LATENCY=4).
// The driver applies one input vector per cycle just after posedge and queues the
// hand-derived expected outputs; the monitor pops and compares on negedge.
module tb_hazard_ctrl;

    localparam logic [3:0] E_RUN   = 4'b1100;  // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
    localparam logic [3:0] E_STALL = 4'b0001;
    localparam logic [3:0] E_BR    = 4'b1011;
    localparam logic [3:0] E_IMEM  = 4'b0010;
    localparam logic [3:0] E_RST   = 4'b1111;

    typedef struct {
        string      tag;
        logic [3:0] ctl;
        logic [1:0] st;
    } exp_t;

    logic       CLK;
    logic       RST;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       ex_mem_read, branch_taken, md_start, imem_ready;
    logic       pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic [1:0] state;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    hazard_ctrl #(.MD_LATENCY(4), .REG_W(5)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .branch_taken (branch_taken),
        .md_start     (md_start),
        .imem_ready   (imem_ready),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .state        (state)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic mr, input logic [4:0] ert,
                        input logic [4:0] rs, input logic [4:0] rt, input logic br,
                        input logic md, input logic im, input logic [3:0] ctl,
                        input logic [1:0] st);
        exp_t e;
        @(posedge CLK);
        #1;
        ex_mem_read  = mr;
        ex_rt        = ert;
        id_rs        = rs;
        id_rt        = rt;
        branch_taken = br;
        md_start     = md;
        imem_ready   = im;
        e.tag = tag;
        e.ctl = ctl;
        e.st  = st;
        sb.push_back(e);
    endtask

    task automatic idle(input string tag, input logic [3:0] ctl, input logic [1:0] st);
        step(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, ctl, st);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".ctl"}, 32'({pc_write, if_id_write, if_id_flush, id_ex_bubble}), 32'(e.ctl));
            chk({e.tag, ".st"}, 32'(state), 32'(e.st));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        ex_mem_read = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0;
        branch_taken = 1'b0; md_start = 1'b0; imem_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.ctl", 32'({pc_write, if_id_write, if_id_flush, id_ex_bubble}), 32'(E_RST));
        chk("rst.st", 32'(state), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        idle("idle", E_RUN, 2'd0);

        // load-use on rs: one stall cycle, then LU_STALL with normal outputs, then RUN
        step("lu_rs", 1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b1, E_STALL, 2'd0);
        idle("lu_rs_s", E_RUN, 2'd1);
        idle("lu_rs_e", E_RUN, 2'd0);
        // load-use on rt
        step("lu_rt", 1'b1, 5'd9, 5'd4, 5'd9, 1'b0, 1'b0, 1'b1, E_STALL, 2'd0);
        idle("lu_rt_s", E_RUN, 2'd1);
        idle("lu_rt_e", E_RUN, 2'd0);
        // load to r0 and non-load match: no stall
        step("lu_r0", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, E_RUN, 2'd0);
        idle("lu_r0_e", E_RUN, 2'd0);
        step("no_ld", 1'b0, 5'd8, 5'd8, 5'd8, 1'b0, 1'b0, 1'b1, E_RUN, 2'd0);

        // multiply/divide: 4 stall cycles; md_start and imem wait ignored inside
        step("md_go", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, E_RUN, 2'd0);
        step("md_w1", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, E_STALL, 2'd2);
        step("md_w2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_STALL, 2'd2);
        idle("md_w3", E_STALL, 2'd2);
        idle("md_w4", E_STALL, 2'd2);
        idle("md_end", E_RUN, 2'd0);

        // branch in 2nd MD_WAIT cycle: flush that cycle, wait ends on schedule
        step("mdb_go", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, E_RUN, 2'd0);
        idle("mdb_w1", E_STALL, 2'd2);
        step("mdb_w2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, E_BR, 2'd2);
        idle("mdb_w3", E_STALL, 2'd2);
        idle("mdb_w4", E_STALL, 2'd2);
        idle("mdb_end", E_RUN, 2'd0);

        // fetch wait for 3 cycles: NOPs in, PC held, state stays RUN
        for (int i = 0; i < 3; i++)
            step($sformatf("imem%0d", i), 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_IMEM, 2'd0);
        idle("imem_end", E_RUN, 2'd0);

        // branch in RUN
        step("br_run", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, E_BR, 2'd0);
        idle("br_run_e", E_RUN, 2'd0);

        // load-use outranks fetch wait
        step("pri_lu", 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, E_STALL, 2'd0);
        idle("pri_lu_s", E_RUN, 2'd1);
        idle("pri_lu_e", E_RUN, 2'd0);

        // fetch wait during LU_STALL, branch during LU_STALL
        step("lus_im", 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, E_STALL, 2'd0);
        step("lus_im_s", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_IMEM, 2'd1);
        idle("lus_im_e", E_RUN, 2'd0);
        step("lus_br", 1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, E_STALL, 2'd0);
        step("lus_br_s", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, E_BR, 2'd1);
        idle("lus_br_e", E_RUN, 2'd0);

        // asynchronous reset in the middle of MD_WAIT
        step("mdr_go", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, E_RUN, 2'd0);
        idle("mdr_w1", E_STALL, 2'd2);
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("mdr_rst.st", 32'(state), 32'd0);
        chk("mdr_rst.ctl", 32'({pc_write, if_id_write, if_id_flush, id_ex_bubble}), 32'(E_RST));
`ifdef HAZARD_PERF_EN
        chk("mdr_rst.stall_cnt", stall_cycles, 32'd0);
        chk("mdr_rst.flush_cnt", flush_cycles, 32'd0);
`endif
        @(negedge CLK);
        RST = 1'b0;
        idle("mdr_after", E_RUN, 2'd0);
        step("pf_im0", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_IMEM, 2'd0);
        step("pf_im1", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_IMEM, 2'd0);
        idle("pf_end", E_RUN, 2'd0);
`ifdef HAZARD_PERF_EN
        @(negedge CLK);
        #1;
        chk("pf.stall_cnt", stall_cycles, 32'd2);
        chk("pf.flush_cnt", flush_cycles, 32'd2);
`endif

        repeat (3) @(negedge CLK);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
